fibonacci_seq: RTL and testbench

Parametrised successor to the fixed 16-bit Fibonacci generator. Produces a generalised Fibonacci sequence (t[n] = t[n-1] + t[n-2]) from loadable seeds, at configurable width. Output uses a valid/ready handshake with a term index and last-term marker. The sequence ends on arithmetic overflow or after a programmed term count. Sits between a control register block (start, seeds, length) and any stream consumer (display formatter, FIFO).

---
 rtl/fibonacci_seq.sv | 108 ++++++++++
 tb/tb_fibonacci_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fibonacci_seq.sv
// Generalised Fibonacci term generator with loadable seeds, a valid/ready output
// stream, and termination on either overflow or a programmed term count.
module fibonacci_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [IDX_W-1:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SUM_W = WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               b_ovf_q, b_ovf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   len_q, len_d;
  logic               last_q, last_d;
  logic               valid_q, busy_q, done_q;
  logic               hs;
  logic [SUM_W-1:0]   sum;

  // Next-state: start always wins; otherwise a handshake advances or finishes.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    b_ovf_d = b_ovf_q;
    idx_d   = idx_q;
    len_d   = len_q;
    hs      = (state_q == S_RUN) && out_ready;
    sum     = SUM_W'(a_q) + SUM_W'(b_q);

    if (start) begin
      state_d = S_RUN;
      a_d     = seed0;
      b_d     = seed1;
      b_ovf_d = 1'b0;
      idx_d   = '0;
      len_d   = len;
    end else if (hs) begin
      if (last_q) begin
        state_d = S_DONE;
      end else begin
        a_d     = b_q;
        b_d     = sum[WIDTH-1:0];
        b_ovf_d = sum[WIDTH];
        idx_d   = IDX_W'(idx_q + IDX_W'(1));
      end
    end

    // Registered copy of the last-term decode so out_last lines up with a_q.
    last_d = (state_d == S_RUN) &&
             (b_ovf_d || ((len_d != '0) && (idx_d == IDX_W'(len_d - IDX_W'(1)))));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      b_ovf_q <= 1'b0;
      idx_q   <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      b_ovf_q <= b_ovf_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      last_q  <= last_d;
      valid_q <= (state_d == S_RUN);
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign out_valid = valid_q;
  assign out_data  = a_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fibonacci_seq.sv
// Directed bench for fibonacci_seq: sequences, back-pressure, restart, reset, index wrap.
module tb_fibonacci_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] seed0, seed1;
  logic [7:0]  len;
  logic        out_valid, out_ready, out_last, busy, done;
  logic [15:0] out_data;
  logic [7:0]  out_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fibonacci_seq #(.WIDTH(16), .IDX_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1), .len(len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] s0, input logic [15:0] s1, input logic [7:0] n);
    seed0 = s0; seed1 = s1; len = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; seed0 = '0; seed1 = '0; len = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++;
    if ({out_valid, out_last, busy, done} !== 4'b0000 || out_data !== 16'd0 || out_idx !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b l=%b b=%b d=%b data=%0d idx=%0d want all zero",
               out_valid, out_last, busy, done, out_data, out_idx);
    end
  endtask

  task automatic test_fib();
    int ea, eb, t, last_seen;
    ea = 0; eb = 1; last_seen = -1;
    out_ready = 1'b1;
    launch(16'd0, 16'd1, 8'd0);
    for (int i = 0; i < 25; i++) begin
      total++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== 16'(ea) || out_idx !== 8'(i) ||
          out_last !== (eb > 65535)) begin
        bad++;
        $display("FAIL fib_term i=%0d got v=%b data=%0d idx=%0d last=%b want data=%0d last=%b",
                 i, out_valid, out_data, out_idx, out_last, ea, (eb > 65535));
      end
      last_seen = int'(out_data);
      tick();
      t = ea + eb; ea = eb; eb = t;
    end
    total++;
    if (last_seen != 46368 || done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL fib_end got last=%0d done=%b v=%b want last=46368 done=1 v=0",
               last_seen, done, out_valid);
    end
  endtask

  task automatic test_lucas();
    int ea, eb, t, i;
    logic fin;
    ea = 2; eb = 1; i = 0; fin = 1'b0;
    out_ready = 1'b1;
    launch(16'd2, 16'd1, 8'd0);
    while (!fin && i < 40) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'(ea) || out_idx !== 8'(i) || out_last !== (eb > 65535)) begin
        bad++;
        $display("FAIL lucas_term i=%0d got data=%0d idx=%0d last=%b want data=%0d last=%b",
                 i, out_data, out_idx, out_last, ea, (eb > 65535));
      end
      if (out_last === 1'b1) begin
        fin = 1'b1;
        total++;
        if (out_idx !== 8'd23 || out_data !== 16'd64079) begin
          bad++;
          $display("FAIL lucas_last got idx=%0d data=%0d want idx=23 data=64079", out_idx, out_data);
        end
      end
      tick();
      t = ea + eb; ea = eb; eb = t; i++;
    end
    total++;
    if (!fin || done !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL lucas_end got fin=%b done=%b v=%b want fin=1 done=1 v=0", fin, done, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int exp_t[5] = '{0, 1, 1, 2, 3};
    logic [31:0] pat;
    int acc, c;
    pat = 32'b1011_0011_1000_1101_0110_0101_1100_1010;
    acc = 0; c = 0;
    out_ready = 1'b0;
    launch(16'd0, 16'd1, 8'd5);
    while (acc < 5 && c < 32) begin
      out_ready = pat[c];
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'(exp_t[acc]) || out_idx !== 8'(acc) ||
          out_last !== (acc == 4)) begin
        bad++;
        $display("FAIL bp_term cyc=%0d got data=%0d idx=%0d last=%b want data=%0d idx=%0d last=%b",
                 c, out_data, out_idx, out_last, exp_t[acc], acc, (acc == 4));
      end
      tick();
      if (pat[c]) acc++;
      c++;
    end
    total++;
    if (acc != 5 || done !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_end got acc=%0d done=%b v=%b want acc=5 done=1 v=0", acc, done, out_valid);
    end
  endtask

  task automatic test_restart();
    int exp_t[3] = '{5, 8, 13};
    out_ready = 1'b1;
    launch(16'd0, 16'd1, 8'd0);
    for (int i = 0; i < 7; i++) tick();
    total++;
    if (out_idx !== 8'd7 || out_data !== 16'd13) begin
      bad++;
      $display("FAIL restart_pre got idx=%0d data=%0d want idx=7 data=13", out_idx, out_data);
    end
    launch(16'd5, 16'd8, 8'd0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'(exp_t[i]) || out_idx !== 8'(i)) begin
        bad++;
        $display("FAIL restart_term i=%0d got data=%0d idx=%0d want data=%0d idx=%0d",
                 i, out_data, out_idx, exp_t[i], i);
      end
      tick();
    end
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b1;
    launch(16'd0, 16'd1, 8'd0);
    for (int i = 0; i < 10; i++) tick();
    out_ready = 1'b0;
    tick();
    total++;
    if (out_idx !== 8'd10 || out_data !== 16'd55 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_stall got idx=%0d data=%0d v=%b want idx=10 data=55 v=1", out_idx, out_data, out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({out_valid, busy, done, out_last} !== 4'b0000 || out_data !== 16'd0 || out_idx !== 8'd0) begin
      bad++;
      $display("FAIL rst_mid got v=%b b=%b d=%b data=%0d idx=%0d want all zero",
               out_valid, busy, done, out_data, out_idx);
    end
    out_ready = 1'b1;
    launch(16'd3, 16'd4, 8'd2);
    total++;
    if (out_data !== 16'd3 || out_idx !== 8'd0 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL rst_relaunch0 got data=%0d idx=%0d last=%b want 3 0 0", out_data, out_idx, out_last);
    end
    tick();
    total++;
    if (out_data !== 16'd4 || out_idx !== 8'd1 || out_last !== 1'b1) begin
      bad++;
      $display("FAIL rst_relaunch1 got data=%0d idx=%0d last=%b want 4 1 1", out_data, out_idx, out_last);
    end
    tick();
    total++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_relaunch_end got done=%b v=%b want done=1 v=0", done, out_valid);
    end
  endtask

  task automatic test_zeros();
    out_ready = 1'b1;
    launch(16'd0, 16'd0, 8'd3);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'd0 || out_idx !== 8'(i) || out_last !== (i == 2)) begin
        bad++;
        $display("FAIL zero_term i=%0d got v=%b data=%0d idx=%0d last=%b want data=0 last=%b",
                 i, out_valid, out_data, out_idx, out_last, (i == 2));
      end
      tick();
    end
    total++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL zero_end got done=%b v=%b want done=1 v=0", done, out_valid);
    end
    launch(16'd1, 16'd1, 8'd2);
    total++;
    if (out_valid !== 1'b1 || done !== 1'b0 || out_data !== 16'd1 || out_idx !== 8'd0) begin
      bad++;
      $display("FAIL done_relaunch got v=%b d=%b data=%0d idx=%0d want v=1 d=0 data=1 idx=0",
               out_valid, done, out_data, out_idx);
    end
    tick(); tick();
    total++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL done_relaunch_end got done=%b v=%b want done=1 v=0", done, out_valid);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    launch(16'd0, 16'd0, 8'd0);
    for (int i = 0; i < 255; i++) tick();
    total++;
    if (out_idx !== 8'd255 || out_valid !== 1'b1 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL wrap_pre got idx=%0d v=%b last=%b want idx=255 v=1 last=0", out_idx, out_valid, out_last);
    end
    tick();
    total++;
    if (out_idx !== 8'd0 || out_valid !== 1'b1 || out_data !== 16'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL wrap_post got idx=%0d v=%b data=%0d busy=%b want idx=0 v=1 data=0 busy=1",
               out_idx, out_valid, out_data, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fib();
    test_lucas();
    test_backpressure();
    test_restart();
    test_rst_mid();
    test_zeros();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
